// File: rtl/tpu_instr_dispatch.sv
// MPU-side dispatcher: streams a header word and then a thread program from
// instruction memory into a TPU request/nack/term port, retrying nacked words.
module tpu_instr_dispatch #(
  parameter int unsigned WIDTH_INSTR = 64,
  parameter int unsigned WIDTH_ID    = 8,
  parameter int unsigned WIDTH_ADDR  = 10,
  parameter int unsigned NACK_LIMIT  = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Start,
  input  logic [WIDTH_ID-1:0]    I_ThreadID,
  input  logic [WIDTH_ADDR-1:0]  I_Base_Addr,
  input  logic [WIDTH_ADDR-1:0]  I_Length,
  input  logic                   I_Abort,
  output logic                   O_IMem_Re,
  output logic [WIDTH_ADDR-1:0]  O_IMem_Addr,
  input  logic [WIDTH_INSTR-1:0] I_IMem_Data,
  output logic                   O_En_Exe,
  output logic                   O_Req,
  output logic [WIDTH_INSTR-1:0] O_Instr,
  input  logic                   I_Nack,
  input  logic                   I_Term,
  output logic                   O_Busy,
  output logic                   O_Done,
  output logic                   O_Error
);

  localparam int unsigned WIDTH_NACK = $clog2(NACK_LIMIT + 1);
  localparam int unsigned WIDTH_PAD  = WIDTH_INSTR - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TERM
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_ADDR-1:0]   remain_q, remain_d;
  logic [WIDTH_NACK-1:0]   nack_q, nack_d, nack_inc;
  logic [WIDTH_ADDR-1:0]   addr_d;
  logic [WIDTH_INSTR-1:0]  instr_d;
  logic                    re_d, en_d, req_d, busy_d, done_d, err_d;
  logic                    to_idle;

  // O_IMem_Addr doubles as the running program address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      nack_q      <= '0;
      O_IMem_Re   <= 1'b0;
      O_IMem_Addr <= '0;
      O_En_Exe    <= 1'b0;
      O_Req       <= 1'b0;
      O_Instr     <= '0;
      O_Busy      <= 1'b0;
      O_Done      <= 1'b0;
      O_Error     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      nack_q      <= nack_d;
      O_IMem_Re   <= re_d;
      O_IMem_Addr <= addr_d;
      O_En_Exe    <= en_d;
      O_Req       <= req_d;
      O_Instr     <= instr_d;
      O_Busy      <= busy_d;
      O_Done      <= done_d;
      O_Error     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    nack_d   = nack_q;
    addr_d   = O_IMem_Addr;
    instr_d  = O_Instr;
    re_d     = 1'b0;
    en_d     = O_En_Exe;
    req_d    = O_Req;
    busy_d   = O_Busy;
    done_d   = 1'b0;
    err_d    = O_Error;
    to_idle  = 1'b0;
    nack_inc = nack_q + WIDTH_NACK'(1);

    // Abort beats a same-cycle termination; early termination is an error
    if (state_q != ST_IDLE && I_Abort) begin
      to_idle = 1'b1;
    end else if (state_q inside {ST_HDR, ST_FETCH, ST_LOAD, ST_SEND} && I_Term) begin
      to_idle = 1'b1;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (I_Start) begin
            state_d  = ST_HDR;
            remain_d = I_Length;
            addr_d   = I_Base_Addr;
            nack_d   = '0;
            instr_d  = {1'b1, WIDTH_PAD'(I_ThreadID)};
            req_d    = 1'b1;
            en_d     = 1'b1;
            busy_d   = 1'b1;
            err_d    = 1'b0;
          end
        end
        ST_HDR, ST_SEND: begin
          if (I_Nack) begin
            if (nack_inc == WIDTH_NACK'(NACK_LIMIT)) begin
              to_idle = 1'b1;
              err_d   = 1'b1;
            end else begin
              nack_d = nack_inc;
            end
          end else begin
            nack_d = '0;
            req_d  = 1'b0;
            if (state_q == ST_SEND) begin
              remain_d = remain_q - WIDTH_ADDR'(1);
              addr_d   = O_IMem_Addr + WIDTH_ADDR'(1);
            end
            if (remain_d != '0) begin
              state_d = ST_FETCH;
              re_d    = 1'b1;
            end else begin
              state_d = ST_WAIT_TERM;
            end
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          instr_d = I_IMem_Data;
          req_d   = 1'b1;
          state_d = ST_SEND;
        end
        ST_WAIT_TERM: begin
          if (I_Term) begin
            done_d  = 1'b1;
            to_idle = 1'b1;
          end
        end
        default: to_idle = 1'b1;
      endcase
    end

    if (to_idle) begin
      state_d = ST_IDLE;
      nack_d  = '0;
      re_d    = 1'b0;
      req_d   = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_tpu_instr_dispatch.sv
// Scoreboard bench for tpu_instr_dispatch: a TPU/memory model feeds randomized
// nacks and program contents; a monitor checks every read and accepted word.
module tb_tpu_instr_dispatch;

  localparam int unsigned WI   = 64;
  localparam int unsigned WID  = 8;
  localparam int unsigned WA   = 10;
  localparam int unsigned NLIM = 5;

  logic           clock;
  logic           reset;
  logic           I_Start;
  logic [WID-1:0] I_ThreadID;
  logic [WA-1:0]  I_Base_Addr;
  logic [WA-1:0]  I_Length;
  logic           I_Abort;
  logic           O_IMem_Re;
  logic [WA-1:0]  O_IMem_Addr;
  logic [WI-1:0]  I_IMem_Data;
  logic           O_En_Exe;
  logic           O_Req;
  logic [WI-1:0]  O_Instr;
  logic           I_Nack;
  logic           I_Term;
  logic           O_Busy;
  logic           O_Done;
  logic           O_Error;

  tpu_instr_dispatch #(
    .WIDTH_INSTR(WI), .WIDTH_ID(WID), .WIDTH_ADDR(WA), .NACK_LIMIT(NLIM)
  ) dut (
    .clock(clock), .reset(reset), .I_Start(I_Start), .I_ThreadID(I_ThreadID),
    .I_Base_Addr(I_Base_Addr), .I_Length(I_Length), .I_Abort(I_Abort),
    .O_IMem_Re(O_IMem_Re), .O_IMem_Addr(O_IMem_Addr), .I_IMem_Data(I_IMem_Data),
    .O_En_Exe(O_En_Exe), .O_Req(O_Req), .O_Instr(O_Instr), .I_Nack(I_Nack),
    .I_Term(I_Term), .O_Busy(O_Busy), .O_Done(O_Done), .O_Error(O_Error)
  );

  logic [WI-1:0] imem [1024];
  logic [WI-1:0] exp_words [$];
  logic [WA-1:0] exp_addrs [$];

  int n_checks;
  int n_fail;
  int done_cnt;
  int nack_total;
  int prog_seq;
  int nack_word;
  int nack_cycles;
  int nack_pct;
  bit nack_forever;
  bit hold_chk;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: one-cycle read latency
  always @(posedge clock) if (O_IMem_Re) I_IMem_Data <= imem[O_IMem_Addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  function automatic logic [WI-1:0] hdr(input logic [WID-1:0] id);
    logic [WI-1:0] w;
    w = WI'(id);
    w[WI-1] = 1'b1;
    return w;
  endfunction

  // TPU side: decides the nack for each cycle a word is presented
  initial begin : tpu_model
    int run, acc_idx, seen_seq;
    logic n;
    run = 0; acc_idx = 0; seen_seq = 0;
    forever begin
      @(negedge clock);
      if (prog_seq != seen_seq) begin
        seen_seq = prog_seq;
        acc_idx  = 0;
        run      = 0;
      end
      n = 1'b0;
      if (reset && O_Req) begin
        if (nack_forever) n = 1'b1;
        else if (acc_idx == nack_word && run < nack_cycles) n = 1'b1;
        else if (run < int'(NLIM) - 1 && int'($urandom_range(99)) < nack_pct) n = 1'b1;
        if (n) begin run++; nack_total++; end
        else begin run = 0; acc_idx++; end
      end else begin
        run = 0;
      end
      I_Nack = n;
    end
  end

  // Monitor: pops expectations for every memory read and accepted word
  initial begin : monitor
    logic          prev_hold;
    logic [WI-1:0] prev_instr;
    logic [WI-1:0] w;
    logic [WA-1:0] a;
    prev_hold = 1'b0;
    prev_instr = '0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        prev_hold = 1'b0;
        continue;
      end
      if (O_Done) done_cnt++;
      if (hold_chk && prev_hold) begin
        chk("nack_hold_req", 64'(O_Req), 64'd1);
        chk("nack_hold_instr", 64'(O_Instr), 64'(prev_instr));
      end
      if (O_IMem_Re) begin
        if (exp_addrs.size() == 0) fail_now("unexpected_read", 64'(O_IMem_Addr));
        else begin
          a = exp_addrs.pop_front();
          chk("read_addr", 64'(O_IMem_Addr), 64'(a));
        end
      end
      if (O_Req && !I_Nack) begin
        if (exp_words.size() == 0) fail_now("unexpected_word", 64'(O_Instr));
        else begin
          w = exp_words.pop_front();
          chk("accepted_word", 64'(O_Instr), 64'(w));
        end
      end
      prev_hold  = O_Req && I_Nack;
      prev_instr = O_Instr;
    end
  end

  task automatic flush();
    exp_words.delete();
    exp_addrs.delete();
  endtask

  task automatic start_prog(input logic [WID-1:0] id, input logic [WA-1:0] base, input int len);
    logic [WA-1:0] a;
    @(negedge clock);
    exp_words.push_back(hdr(id));
    for (int i = 0; i < len; i++) begin
      a = WA'((int'(base) + i) % 1024);
      exp_addrs.push_back(a);
      exp_words.push_back(imem[a]);
    end
    I_ThreadID  = id;
    I_Base_Addr = base;
    I_Length    = WA'(len);
    I_Start     = 1'b1;
    prog_seq++;
    @(negedge clock);
    I_Start = 1'b0;
    #2;
    chk("start_busy", 64'(O_Busy), 64'd1);
    chk("start_en_exe", 64'(O_En_Exe), 64'd1);
    chk("start_error_clear", 64'(O_Error), 64'd0);
  endtask

  task automatic wait_words(input bit garbage);
    int budget;
    budget = 0;
    forever begin
      @(negedge clock);
      I_Start = 1'b0;
      #2;
      if (exp_words.size() == 0) break;
      if (budget >= 400) begin
        fail_now("words_timeout", 64'(exp_words.size()));
        flush();
        break;
      end
      if (garbage && $urandom_range(9) == 0) begin
        I_Start     = 1'b1;
        I_ThreadID  = WID'($urandom);
        I_Base_Addr = WA'($urandom);
        I_Length    = WA'($urandom);
      end
      budget++;
    end
  endtask

  task automatic run_program(input logic [WID-1:0] id, input logic [WA-1:0] base,
                             input int len, input int term_delay, input bit garbage);
    int d0;
    d0 = done_cnt;
    start_prog(id, base, len);
    wait_words(garbage);
    repeat (term_delay + 1) @(negedge clock);
    #2;
    chk("wait_term_req", 64'(O_Req), 64'd0);
    chk("wait_term_busy", 64'(O_Busy), 64'd1);
    chk("no_early_done", 64'(done_cnt), 64'(d0));
    I_Term = 1'b1;
    @(negedge clock);
    I_Term = 1'b0;
    #2;
    chk("done_pulse", 64'(O_Done), 64'd1);
    chk("done_busy", 64'(O_Busy), 64'd0);
    chk("done_en_exe", 64'(O_En_Exe), 64'd0);
    chk("done_error", 64'(O_Error), 64'd0);
    chk("reads_all", 64'(exp_addrs.size()), 64'd0);
    @(negedge clock);
    #2;
    chk("done_one_cycle", 64'(O_Done), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(d0 + 1));
  endtask

  initial begin : watchdog
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, d0, budget;
    n_checks = 0; n_fail = 0; done_cnt = 0; nack_total = 0; prog_seq = 0;
    nack_word = -1; nack_cycles = 0; nack_pct = 0; nack_forever = 1'b0; hold_chk = 1'b1;
    reset = 1'b0; I_Start = 1'b0; I_ThreadID = '0; I_Base_Addr = '0; I_Length = '0;
    I_Abort = 1'b0; I_Term = 1'b0; I_Nack = 1'b0;
    for (int i = 0; i < 1024; i++) imem[i] = {$urandom, $urandom};
    imem[16] = 64'hA5A5_0000_1111_000A;
    imem[17] = 64'hB0B0_2222_3333_000B;
    imem[18] = 64'hC3C3_4444_5555_000C;

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", 64'(O_Req), 64'd0);
    chk("rst_busy", 64'(O_Busy), 64'd0);
    chk("rst_en_exe", 64'(O_En_Exe), 64'd0);
    chk("rst_instr", 64'(O_Instr), 64'd0);
    chk("rst_re", 64'(O_IMem_Re), 64'd0);
    chk("rst_addr", 64'(O_IMem_Addr), 64'd0);
    chk("rst_done", 64'(O_Done), 64'd0);
    chk("rst_error", 64'(O_Error), 64'd0);
    reset = 1'b1;

    // Basic program, no nacks, terminate 4 cycles after the last word
    run_program(8'h05, 10'h010, 3, 3, 1'b0);
    // Address wrap
    run_program(8'h21, 10'h3FF, 2, 0, 1'b0);
    // Third word (B) nacked 4 times in a row
    nack_word = 2; nack_cycles = 4; n0 = nack_total;
    run_program(8'h05, 10'h010, 3, 1, 1'b0);
    chk("nackB_count", 64'(nack_total - n0), 64'd4);
    nack_word = -1; nack_cycles = 0;
    // Header only
    run_program(8'hA7, 10'h123, 0, 2, 1'b0);

    // Nack limit on the header
    nack_forever = 1'b1; hold_chk = 1'b0; n0 = nack_total; d0 = done_cnt;
    start_prog(8'h7E, 10'h020, 2);
    budget = 0;
    while (!O_Error && budget < 30) begin
      @(negedge clock);
      #2;
      budget++;
    end
    chk("nacklim_error", 64'(O_Error), 64'd1);
    chk("nacklim_req", 64'(O_Req), 64'd0);
    chk("nacklim_busy", 64'(O_Busy), 64'd0);
    chk("nacklim_en_exe", 64'(O_En_Exe), 64'd0);
    chk("nacklim_nacks", 64'(nack_total - n0), 64'(NLIM));
    chk("nacklim_no_accept", 64'(exp_words.size()), 64'd3);
    chk("nacklim_no_done", 64'(done_cnt), 64'(d0));
    flush();
    nack_forever = 1'b0; hold_chk = 1'b1;
    // Next start clears the sticky error (checked in start_prog)
    run_program(8'h11, 10'h040, 1, 0, 1'b0);

    // Termination while fetching
    d0 = done_cnt;
    start_prog(8'h44, 10'h050, 3);
    budget = 0;
    while (!O_IMem_Re && budget < 30) begin
      @(negedge clock);
      #2;
      budget++;
    end
    chk("fetch_seen", 64'(O_IMem_Re), 64'd1);
    I_Term = 1'b1;
    @(negedge clock);
    I_Term = 1'b0;
    #2;
    chk("early_term_error", 64'(O_Error), 64'd1);
    chk("early_term_busy", 64'(O_Busy), 64'd0);
    chk("early_term_req", 64'(O_Req), 64'd0);
    chk("early_term_words_left", 64'(exp_words.size()), 64'd3);
    chk("early_term_no_done", 64'(done_cnt), 64'(d0));
    flush();

    // Abort and termination together while waiting for termination
    d0 = done_cnt;
    start_prog(8'h66, 10'h200, 1);
    wait_words(1'b0);
    @(negedge clock);
    I_Abort = 1'b1;
    I_Term  = 1'b1;
    @(negedge clock);
    I_Abort = 1'b0;
    I_Term  = 1'b0;
    #2;
    chk("abort_busy", 64'(O_Busy), 64'd0);
    chk("abort_en_exe", 64'(O_En_Exe), 64'd0);
    chk("abort_error", 64'(O_Error), 64'd0);
    @(negedge clock);
    #2;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));

    // Asynchronous reset while a word is being presented
    start_prog(8'h33, 10'h100, 4);
    budget = 0;
    while (!(O_Req && exp_words.size() < 5) && budget < 40) begin
      @(negedge clock);
      #2;
      budget++;
    end
    chk("midsend_req", 64'(O_Req), 64'd1);
    reset = 1'b0;
    #1;
    chk("midsend_rst_req", 64'(O_Req), 64'd0);
    chk("midsend_rst_busy", 64'(O_Busy), 64'd0);
    chk("midsend_rst_en_exe", 64'(O_En_Exe), 64'd0);
    chk("midsend_rst_instr", 64'(O_Instr), 64'd0);
    chk("midsend_rst_addr", 64'(O_IMem_Addr), 64'd0);
    flush();
    @(negedge clock);
    reset = 1'b1;
    run_program(8'h34, 10'h101, 2, 1, 1'b0);

    // Randomized programs with random nacks and stray start pulses
    nack_pct = 30;
    for (int k = 0; k < 12; k++)
      run_program(WID'($urandom), WA'($urandom), int'($urandom_range(7)),
                  int'($urandom_range(4)), 1'b1);
    nack_pct = 0;

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_instr_dispatch.md
Name: tpu_instr_dispatch

Overview:
- MPU-side sender that streams one thread program from MPU instruction memory into a TPU's request/instruction/nack/term interface.
- Accepts a start command carrying thread ID, base address and length. Sends a header word, then each instruction word, retrying any word the TPU nacks.
- Then waits for TPU termination and reports done or error to the MPU sequencer.

Parameters:
- WIDTH_INSTR, 64, instruction word width (same as TPU instruction type)
- WIDTH_ID, 8, thread ID width
- WIDTH_ADDR, 10, instruction memory address width
- NACK_LIMIT, 255, consecutive nacks on one word before error

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- I_Start  in  1  start pulse; sampled only in IDLE
- I_ThreadID  in  WIDTH_ID  thread ID for the header word
- I_Base_Addr  in  WIDTH_ADDR  first instruction address
- I_Length  in  WIDTH_ADDR  number of instruction words after the header
- I_Abort  in  1  abandon the current program
- O_IMem_Re  out  1  instruction memory read enable
- O_IMem_Addr  out  WIDTH_ADDR  instruction memory read address
- I_IMem_Data  in  WIDTH_INSTR  read data, valid 1 cycle after O_IMem_Re
- O_En_Exe  out  1  TPU execute enable
- O_Req  out  1  word valid to TPU
- O_Instr  out  WIDTH_INSTR  word to TPU
- I_Nack  in  1  TPU refuses the word presented this cycle
- I_Term  in  1  TPU reports thread termination
- O_Busy  out  1  program in flight
- O_Done  out  1  one-cycle pulse on clean completion
- O_Error  out  1  sticky error flag; cleared by the next accepted I_Start

Behaviour:
- Reset (reset==0, async): state IDLE. All outputs 0. Address, remaining count and nack counter cleared.
- States: IDLE, HDR, FETCH, LOAD, SEND, WAIT_TERM.
- IDLE
  - I_Start=1: latch ID, base and length; clear O_Error; go to HDR.
  - O_Busy=1 in every state except IDLE.
- O_En_Exe: set on leaving IDLE; cleared on return to IDLE.
- HDR
  - O_Req=1. O_Instr = {1'b1, zeros, ThreadID}: MSB marks a header, ID in the low WIDTH_ID bits.
  - On accept: go to FETCH if length>0, else WAIT_TERM.
- Acceptance rule: a word is accepted in a cycle with O_Req=1 and I_Nack=0. On nack, hold O_Req=1 and the identical O_Instr next cycle.
- FETCH: O_IMem_Re=1 for exactly one cycle, O_IMem_Addr = current address; go to LOAD.
- LOAD: capture I_IMem_Data into the output register; go to SEND.
- SEND
  - O_Req=1, O_Instr = captured word.
  - On accept: decrement remaining count and increment address (wraps modulo 2^WIDTH_ADDR).
  - Then go to FETCH if remaining > 0, else WAIT_TERM.
- Throughput: one instruction per 3 cycles with no nacks. The header takes 1 cycle.
- Nack counter
  - Counts consecutive nacks on the current word; reset on accept.
  - Reaching NACK_LIMIT: set O_Error, drop O_Req, return to IDLE; no O_Done.
- WAIT_TERM: O_Req=0. I_Term=1 → O_Done pulse for one cycle, return to IDLE.
- I_Term before all words are sent (any state other than WAIT_TERM, IDLE): set O_Error, return to IDLE; no O_Done.
- I_Abort in any non-IDLE state: next cycle IDLE, O_Req=0, O_En_Exe=0; O_Error not set.
  - I_Abort and I_Term in the same cycle: abort wins.
- I_Start outside IDLE is ignored.
- I_Term and I_Nack are ignored in IDLE.
- O_Instr holds its last value when O_Req=0.

Test Plan:
- Reset mid-SEND (reset low for 1 cycle with O_Req=1) → all outputs 0 immediately, state IDLE. A following I_Start works normally.
- Start ID=0x05, base=0x010, length=3, IMem[0x10..0x12]=A,B,C, no nacks:
  - Accepted words: header 0x8000_0000_0000_0005, then A, B, C.
  - Reads at 0x010, 0x011, 0x012.
  - I_Term 4 cycles later → O_Done pulses 1 cycle, O_Busy falls.
- Base=0x3FF, length=2 → reads at 0x3FF then 0x000 (wrap); both words delivered.
- Nack B for 4 cycles → B presented unchanged for 5 cycles, accepted once. C follows with correct order; no error.
- NACK_LIMIT=3, nack header continuously → O_Error=1 after 3rd nack, O_Req=0, IDLE, no O_Done. Next I_Start clears O_Error.
- Length=0 → header only, then WAIT_TERM.
- I_Term during FETCH → O_Error=1.
- I_Abort with I_Term same cycle → IDLE, O_Error=0, no O_Done.
